demux_buffered: RTL

- Buffered 1:2 demultiplexer; the reverse direction of the 2:1 `mux`.
- Accepts one WIDTH-bit word per handshake on a single input and routes it to output lane 0 or lane 1 according to `select`.
- Each lane has its own DEPTH-entry FIFO and a valid/ready handshake, so one stalled consumer never blocks delivery already queued on the other lane.
- Sits between the CPU datapath result bus and two destination units, such as the register-file write port and the memory-write port.

---
 rtl/demux_buffered.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux_buffered.sv
// demux_buffered: buffered 1:2 demultiplexer.
// One WIDTH-bit word per input handshake is routed to lane 0 or lane 1 by
// `select`. Each lane owns a DEPTH-entry FIFO and a valid/ready output, so a
// stalled consumer on one lane never blocks words already queued on the other.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   data, select          input word and destination lane (0 or 1)
//   in_valid, in_ready    input handshake; in_ready = target lane not full
//   data0, valid0, ready0 lane 0 head word and handshake (data0 = 0 when empty)
//   data1, valid1, ready1 lane 1 head word and handshake (data1 = 0 when empty)
//   sent0, sent1          wrapping per-lane delivered-word counters
module demux_buffered #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data0,
  output logic             valid0,
  input  logic             ready0,
  output logic [WIDTH-1:0] data1,
  output logic             valid1,
  input  logic             ready1,
  output logic [CNT_W-1:0] sent0,
  output logic [CNT_W-1:0] sent1
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [1:0]             full;
  logic [1:0]             empty;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             lane_ready;
  logic [1:0][WIDTH-1:0]  head;
  logic [1:0][CNT_W-1:0]  sent_cnt;

  // Acceptance depends only on the selected lane's occupancy.
  assign in_ready   = select ? !full[1] : !full[0];
  assign push[0]    = in_valid && in_ready && !select;
  assign push[1]    = in_valid && in_ready && select;
  assign lane_ready = {ready1, ready0};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [CNT_W-1:0] sent_q;

    assign full[g]     = (occ_q == DEPTH_OCC);
    assign empty[g]    = (occ_q == '0);
    assign pop[g]      = !empty[g] && lane_ready[g];
    // Storage is not reset; the head is masked to zero while the lane is empty.
    assign head[g]     = empty[g] ? '0 : mem_q[rd_ptr_q];
    assign sent_cnt[g] = sent_q;

    always_comb begin
      occ_d = occ_q;
      unique case ({push[g], pop[g]})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem_q[wr_ptr_q] <= data;
      end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        sent_q   <= '0;
      end else begin
        occ_q <= occ_d;
        if (push[g]) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop[g]) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          sent_q   <= sent_q + 1'b1;
        end
      end
    end
  end

  assign data0  = head[0];
  assign data1  = head[1];
  assign valid0 = !empty[0];
  assign valid1 = !empty[1];
  assign sent0  = sent_cnt[0];
  assign sent1  = sent_cnt[1];

endmodule
